debounce_multi: RTL
===================

Name: debounce_multi

Overview:
- Parametrised, multi-channel successor to the single-bit switch debouncer.
- Each of CH asynchronous inputs (buttons, switches, mechanical contacts) is synchronised, then filtered with a per-channel stable-time counter.
- Outputs: debounced levels, one-cycle rise/fall event pulses and per-channel busy flags for the front-panel/input-capture logic.
- A shared, runtime-selectable debounce period picks one of four parameterised tick counts.

Parameters:
- CH, 4, number of independent channels (≥1).
- CW, 19, per-channel counter width; must satisfy 2^CW > max(P0..P3).
- P0, 50000, period select 0 target, in clk cycles (5 ms at 10 MHz).
- P1, 100000, period select 1 target, in clk cycles.
- P2, 200000, period select 2 target, in clk cycles.
- P3, 500000, period select 3 target, in clk cycles.
- SYNC, 2, synchroniser depth in flops (≥2).
- RST_VAL, 0, reset level of the synchroniser flops and dout, applied to all channels.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  1 = filter active; 0 = bypass.
- period  in  2  selects target T = P0/P1/P2/P3 for all channels; sampled every cycle.
- din  in  CH  raw asynchronous inputs.
- dout  out  CH  debounced levels (registered).
- rise  out  CH  one-cycle pulse when dout[i] goes 0->1 (registered).
- fall  out  CH  one-cycle pulse when dout[i] goes 1->0 (registered).
- busy  out  CH  1 while channel i counter is nonzero (registered).

Behaviour:
- Reset (async, while rst=1):
  - Synchroniser flops = RST_VAL.
  - dout = {CH{RST_VAL}}.
  - Counters = 0.
  - rise = fall = busy = 0.
  - No pulses are generated on reset deassertion.
- Synchroniser:
  - din[i] passes through SYNC flops to give s[i].
  - The synchroniser runs regardless of en.
- Filter (en=1), per channel, per edge:
  - s[i] == dout[i]: counter <= 0 and dout holds. Any glitch shorter than T restarts the count.
  - s[i] != dout[i] and counter < T-1: counter <= counter+1.
  - s[i] != dout[i] and counter >= T-1: dout[i] <= s[i], counter <= 0, and rise[i] or fall[i] = 1 on the same edge for exactly one cycle.
- Latency:
  - A clean step on din is reflected on dout exactly SYNC+T rising edges after the first edge that samples the new level.
  - rise/fall assert on the same edge dout changes.
- Comparison width: use >= T-1, not ==. If period is reduced mid-count so that counter > new T-1, the channel commits on the next edge where s != dout. The counter never wraps.
- A period increase mid-count keeps the current counter value and continues counting to the new T-1.
- Bypass (en=0):
  - dout[i] <= s[i] every cycle and counters are held at 0.
  - rise/fall still pulse on any dout change, so the event path works in bypass.
- en 1->0 mid-count: the counter is discarded and dout follows s on the next edge.
- en 0->1: filtering starts from counter 0 with the current dout.
- Channels are fully independent; simultaneous commits on several channels are allowed in one cycle.
- rise and fall are never both high for the same channel.
- busy[i] = (counter[i] != 0), registered alongside the counter.
- Arithmetic: unsigned CW-bit counters. T-1 is computed at elaboration for each P. No combinational path from din to any output.
- Implementation: one generate loop over CH plus a shared period mux; expected 150–250 lines.

Test Plan (bench overrides P0=4, P1=8, P2=16, P3=32, SYNC=2, CH=4, RST_VAL=0):
- Reset/idle: rst pulse, din=0, en=1 -> dout=0, rise=fall=busy=0 throughout and no pulse at reset release.
- Clean step, period=0: din[0] 0->1 held -> dout[0]=1 exactly 6 edges after the first sampling edge; rise[0] high for 1 cycle on that edge; busy[0] high for 3 cycles before it.
- Bounce: din[1] toggles 1,0,1,0 with 2-cycle widths then holds 1, period=1 -> no change until 8 stable cycles after sync; exactly one rise[1] and no fall[1].
- Period change mid-count: period=3, din[2]=1 held, counter reaches 10, then period=0 -> dout[2]=1 on the next edge (counter >= 3); one rise[2].
- Bypass: en=0, din[3] 1-cycle glitch -> dout[3] shows a 1-cycle high 2 edges later, with rise then fall pulses. Then en=1 with the same glitch -> dout[3] unchanged, no pulses.
- Async reset mid-count: period=2, din=4'hF, assert rst at count 7 -> all outputs 0 immediately without waiting for clk. After release, a full 2+16 edges elapse before dout=4'hF with 4 simultaneous rise pulses.

Source files
------------

// File: rtl/debounce_multi.sv
// Purpose : multi-channel switch/contact debouncer. Each input is synchronised,
//           then filtered by a per-channel stable-time counter whose target is
//           chosen at runtime from four parameterised periods.
// Latency : a clean step appears on dout SYNC+T edges after the first edge that
//           samples it (T = selected period); bypass gives SYNC+1 edges.
// Backpr. : none. This is a free-running level filter with no handshake.
//
// Ports:
//   clk     system clock, rising edge
//   rst     asynchronous active-high reset
//   en      1 = filter active, 0 = bypass (dout follows synchronised input)
//   period  shared selector of target period P0..P3, used every cycle
//   din     raw asynchronous inputs, one bit per channel
//   dout    debounced levels (registered)
//   rise    one-cycle pulse on a dout 0->1 change (registered)
//   fall    one-cycle pulse on a dout 1->0 change (registered)
//   busy    channel counter is nonzero (registered)
module debounce_multi #(
  parameter int CH      = 4,
  parameter int CW      = 19,
  parameter int P0      = 50000,
  parameter int P1      = 100000,
  parameter int P2      = 200000,
  parameter int P3      = 500000,
  parameter int SYNC    = 2,
  parameter bit RST_VAL = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [1:0]    period,
  input  logic [CH-1:0] din,
  output logic [CH-1:0] dout,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall,
  output logic [CH-1:0] busy
);

  // Commit thresholds are precomputed so the per-channel compare is against a
  // constant-width value and no subtractor is built in the datapath.
  localparam logic [CW-1:0] TM1_0 = CW'(P0 - 1);
  localparam logic [CW-1:0] TM1_1 = CW'(P1 - 1);
  localparam logic [CW-1:0] TM1_2 = CW'(P2 - 1);
  localparam logic [CW-1:0] TM1_3 = CW'(P3 - 1);

  // Shared period mux feeding every channel.
  logic [CW-1:0] w_tgt_m1;

  always_comb begin
    w_tgt_m1 = TM1_0;
    case (period)
      2'd0:    w_tgt_m1 = TM1_0;
      2'd1:    w_tgt_m1 = TM1_1;
      2'd2:    w_tgt_m1 = TM1_2;
      2'd3:    w_tgt_m1 = TM1_3;
      default: w_tgt_m1 = TM1_0;
    endcase
  end

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic [SYNC-1:0] r_sync;
    logic [CW-1:0]   r_cnt;
    logic            r_dout;
    logic            r_rise;
    logic            r_fall;
    logic            r_busy;

    logic            w_s;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_dout_nxt;

    // Synchroniser runs independently of en so that bypass and filter mode
    // see the same resynchronised level.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sync <= {SYNC{RST_VAL}};
      end else begin
        r_sync <= {r_sync[SYNC-2:0], din[gi]};
      end
    end

    assign w_s = r_sync[SYNC-1];

    // Next-state for counter and level. The threshold uses >= so that a
    // period shortened mid-count commits at once rather than letting the
    // counter run on and wrap.
    always_comb begin
      w_cnt_nxt  = '0;
      w_dout_nxt = r_dout;
      if (!en) begin
        w_dout_nxt = w_s;
      end else if (w_s != r_dout) begin
        if (r_cnt >= w_tgt_m1) begin
          w_dout_nxt = w_s;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt  <= '0;
        r_dout <= RST_VAL;
        r_rise <= 1'b0;
        r_fall <= 1'b0;
        r_busy <= 1'b0;
      end else begin
        r_cnt  <= w_cnt_nxt;
        r_dout <= w_dout_nxt;
        // Edge pulses derive from the level change itself, so they work the
        // same in filter and bypass mode and can never both be high.
        r_rise <= w_dout_nxt & ~r_dout;
        r_fall <= ~w_dout_nxt & r_dout;
        r_busy <= (w_cnt_nxt != '0);
      end
    end

    assign dout[gi] = r_dout;
    assign rise[gi] = r_rise;
    assign fall[gi] = r_fall;
    assign busy[gi] = r_busy;
  end

endmodule
